// File: rtl/result_uart_streamer.sv
// Purpose: buffers 16-bit result words in a FIFO and sends each as two 8N1 UART frames, low byte first.
// Latency: word pushed at edge N into an empty FIFO is popped at N+1; tx falls at N+2; 20 bit-times per word.
// Backpressure: none upstream; a word arriving with the FIFO full and no pop is dropped and overflow sticks.
module result_uart_streamer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       in_data,
  input  logic              in_valid,
  output logic              tx,
  output logic              tx_busy,
  output logic              fifo_full,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_nxt;
  logic [15:0]         mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W:0]     count;
  logic [15:0]         hold;
  logic                byte_sel;
  logic [2:0]          bit_idx;
  logic [CNT_W-1:0]    baud_cnt;
  logic                tx_reg, tx_nxt;
  logic                push, pop, bit_done;
  logic [7:0]          cur_byte;

  assign bit_done   = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign fifo_full  = (count == (ADDR_W+1)'(FIFO_DEPTH));
  // The FSM is the only reader; it takes the head word whenever it is idle.
  assign pop        = (state == IDLE) && (count != '0);
  // A simultaneous pop frees a slot, so a full FIFO can still accept that cycle.
  assign push       = in_valid && (!fifo_full || pop);
  assign fifo_count = count;
  assign tx_busy    = (state != IDLE) || (count != '0);
  assign tx         = tx_reg;
  assign cur_byte   = byte_sel ? hold[15:8] : hold[7:0];

  // Next-state and next line level; tx is registered so it lags state by one clk.
  always_comb begin
    state_nxt = state;
    tx_nxt    = 1'b1;
    case (state)
      IDLE:  if (pop) state_nxt = START;
      START: begin
        tx_nxt = 1'b0;
        if (bit_done) state_nxt = DATA;
      end
      DATA: begin
        tx_nxt = cur_byte[bit_idx];
        if (bit_done && (bit_idx == 3'd7)) state_nxt = STOP;
      end
      STOP:  if (bit_done) state_nxt = byte_sel ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and glitch-free line register; reset forces the line idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      tx_reg <= 1'b1;
    end else begin
      state  <= state_nxt;
      tx_reg <= tx_nxt;
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers, occupancy and sticky loss flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      if (in_valid && !push) overflow <= 1'b1;
    end
  end

  // Serialiser datapath: holding register, byte select, bit index and baud counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold     <= '0;
      byte_sel <= 1'b0;
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else if (pop) begin
      hold     <= mem[rd_ptr];
      byte_sel <= 1'b0;
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else if (state != IDLE) begin
      baud_cnt <= bit_done ? '0 : baud_cnt + CNT_W'(1);
      if (bit_done) begin
        if (state == START) bit_idx <= '0;
        if (state == DATA)  bit_idx <= bit_idx + 3'd1;
        if (state == STOP)  byte_sel <= 1'b1;
      end
    end
  end

endmodule

// File: doc/result_uart_streamer.md
Name: result_uart_streamer

Overview:
- Downstream consumer of the processor's registered 16-bit memory-write word stream.
- Buffers each valid result word in a small FIFO and serialises it over a UART TX line, 8N1, low byte first, for host-side readback of matrix results.
- Sits between the processor top and the board TX pin.
- The processor stalls never: this block must absorb bursts and flag loss.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- FIFO_DEPTH, 16, word entries; power of two.
- ADDR_W, 4, log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  16  result word (processor to_mem).
- in_valid  input  1  in_data is a new word this cycle (registered dm write strobe, aligned with to_mem).
- tx  output  1  UART serial out, idle high.
- tx_busy  output  1  high while a frame is being shifted or the FIFO is non-empty.
- fifo_full  output  1  FIFO holds FIFO_DEPTH words.
- fifo_count  output  ADDR_W+1  words currently buffered.
- overflow  output  1  sticky: a valid word was dropped.

Behaviour:
- Reset (async assert, sync release): tx=1, tx_busy=0, fifo_full=0, fifo_count=0, overflow=0, FSM=IDLE, pointers=0, baud counter=0, bit index=0.
- Reset mid-frame: line returns high immediately; the partial frame is abandoned and all buffered words are discarded.
- FIFO push: on posedge with in_valid=1, the word is written if fifo_count<FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the word is dropped and overflow is set; overflow stays set until rst.
- FIFO pop: performed only by the FSM in IDLE when fifo_count>0.
- Simultaneous push and pop: fifo_count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. fifo_full = (fifo_count==FIFO_DEPTH).
- FSM states and transitions:
  - IDLE: when count>0, pop the head word into a 16-bit holding register, set byte_sel=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
  - DATA: tx = selected byte bit[index], LSB first. Each bit is held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if byte_sel=0, set byte_sel=1 and go to START (high byte). Otherwise go to IDLE.
- Byte order: low byte in_data[7:0] first, then in_data[15:8].
- Frame length: 20 bit-times per word. There is no idle gap between the two bytes of a word.
- Back-to-back words: the IDLE→START hop adds exactly 1 clk between words.
- Latency: a word accepted at edge N into an empty FIFO is popped at edge N+1. tx falls at edge N+2.
- Baud counter counts 0..CLKS_PER_BIT-1 and reloads at each bit boundary. No fractional baud.
- tx is driven from a register (glitch-free).
- tx_busy = (FSM≠IDLE) or (fifo_count>0).
- in_data is sampled only on accepted pushes; it is ignored while in_valid=0.

Test Plan:
- Reset then idle 100 cycles → tx=1, tx_busy=0, fifo_count=0, overflow=0.
- CLKS_PER_BIT=4; push 0xA55A at edge N → tx low from edge N+2 for 4 cycles. Decoded bytes are 0x5A then 0xA5 with stop bits high. Frame ends after 80 cycles. tx_busy falls on the cycle the FSM returns to IDLE.
- Push 3 words 0x0001, 0x1234, 0xFFFF on consecutive cycles → 6 bytes decoded in order 01 00 34 12 FF FF. fifo_count peaks at 2.
- Push 18 words on consecutive cycles while the first frame is active → 1 word popped, 16 buffered, fifo_full=1. The word at push 18 is dropped and overflow=1. Exactly 17 words are transmitted, and overflow stays 1.
- FIFO full with a pop coinciding with in_valid → the word is accepted, fifo_count stays 16, overflow unchanged.
- Assert rst during the DATA state of the high byte → tx=1 asynchronously, count=0. After release with no pushes, no further start bit appears.
